// File: rtl/mult_taint_pkg.sv
// Shared definitions between the multiplier controller and its datapath:
// the strobe bundle and the word-level taint rule for loadable registers.
package mult_taint_pkg;

  typedef struct packed {
    logic mdld;
    logic mdld_t;
    logic mrld;
    logic mrld_t;
    logic rsclear;
    logic rsclear_t;
    logic rsload;
    logic rsload_t;
    logic rsshr;
    logic rsshr_t;
    logic productDone;
    logic productDone_t;
  } strobe_t;

  // A tainted enable means either load outcome was possible, so the result is tainted.
  function automatic logic taint_load(input logic en,
                                      input logic en_t,
                                      input logic old_t,
                                      input logic data_t);
    logic res;
    res = old_t;
    if (en_t) begin
      res = 1'b1;
    end else if (en) begin
      res = data_t;
    end
    return res;
  endfunction

endpackage

// File: rtl/taint_load_reg.sv
// Data register with load enable and a single word-level taint bit that
// follows the shared load taint rule.
module taint_load_reg
  import mult_taint_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         en_t,
  input  logic [W-1:0] d,
  input  logic         d_t,
  output logic [W-1:0] q,
  output logic         q_t
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q   <= '0;
      q_t <= 1'b0;
    end else begin
      if (en) begin
        q <= d;
      end
      q_t <= taint_load(en, en_t, q_t, d_t);
    end
  end

endmodule

// File: rtl/multiplier_datapath_taint_track_word.sv
// Shift-add multiplier datapath with word-level taint tracking: operand
// registers, carry-extended result register and a product holding register.
module multiplier_datapath_taint_track_word
  import mult_taint_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   multiplicand_in,
  input  logic               multiplicand_in_t,
  input  logic [WIDTH-1:0]   multiplier_in,
  input  logic               multiplier_in_t,
  input  logic               mdld,
  input  logic               mdld_t,
  input  logic               mrld,
  input  logic               mrld_t,
  input  logic               rsclear,
  input  logic               rsclear_t,
  input  logic               rsload,
  input  logic               rsload_t,
  input  logic               rsshr,
  input  logic               rsshr_t,
  input  logic               productDone,
  input  logic               productDone_t,
  output logic [WIDTH-1:0]   multiplierReg,
  output logic               multiplierReg_t,
  output logic [2*WIDTH-1:0] product,
  output logic               product_t,
  output logic               product_valid,
  output logic               product_valid_t
);

  localparam int PW = 2 * WIDTH;

  strobe_t strb;

  logic [WIDTH-1:0] md;
  logic             md_t;
  logic [WIDTH-1:0] mr;
  logic             mr_t;

  logic [PW:0] rs;
  logic        rs_t;
  logic [PW:0] rs_next;
  logic        rs_t_next;

  logic pending;
  logic pend_t;

  assign strb = '{mdld:          mdld,
                  mdld_t:        mdld_t,
                  mrld:          mrld,
                  mrld_t:        mrld_t,
                  rsclear:       rsclear,
                  rsclear_t:     rsclear_t,
                  rsload:        rsload,
                  rsload_t:      rsload_t,
                  rsshr:         rsshr,
                  rsshr_t:       rsshr_t,
                  productDone:   productDone,
                  productDone_t: productDone_t};

  taint_load_reg #(.W(WIDTH)) u_md_reg (
    .clk  (clk),
    .rst  (rst),
    .en   (strb.mdld),
    .en_t (strb.mdld_t),
    .d    (multiplicand_in),
    .d_t  (multiplicand_in_t),
    .q    (md),
    .q_t  (md_t)
  );

  taint_load_reg #(.W(WIDTH)) u_mr_reg (
    .clk  (clk),
    .rst  (rst),
    .en   (strb.mrld),
    .en_t (strb.mrld_t),
    .d    (multiplier_in),
    .d_t  (multiplier_in_t),
    .q    (mr),
    .q_t  (mr_t)
  );

  assign multiplierReg   = mr;
  assign multiplierReg_t = mr_t;

  // The add ignores the old carry: the upper half plus md always fits in WIDTH+1 bits.
  always_comb begin
    rs_next = rs;
    if (strb.rsclear) begin
      rs_next = '0;
    end else if (strb.rsload) begin
      rs_next[PW:WIDTH] = {1'b0, rs[PW-1:WIDTH]} + {1'b0, md};
    end else if (strb.rsshr) begin
      rs_next = {1'b0, rs[PW:1]};
    end

    rs_t_next = 1'b0;
    if (!(strb.rsclear && !strb.rsclear_t)) begin
      rs_t_next = rs_t | strb.rsclear_t | strb.rsload_t | strb.rsshr_t
                | ((strb.rsload | strb.rsload_t) & md_t);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rs   <= '0;
      rs_t <= 1'b0;
    end else begin
      rs   <= rs_next;
      rs_t <= rs_t_next;
    end
  end

  // Capture one edge after productDone, once the final shift has landed in rs.
  // A repeated productDone keeps the capture pending for another edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending         <= 1'b0;
      pend_t          <= 1'b0;
      product         <= '0;
      product_t       <= 1'b0;
      product_valid   <= 1'b0;
      product_valid_t <= 1'b0;
    end else begin
      pend_t          <= strb.productDone_t;
      product_valid_t <= pend_t;
      product_valid   <= 1'b0;
      if (strb.productDone) begin
        pending <= 1'b1;
      end else if (pending) begin
        product       <= rs[PW-1:0];
        product_t     <= rs_t | pend_t;
        product_valid <= 1'b1;
        pending       <= 1'b0;
      end
    end
  end

endmodule

// File: doc/multiplier_datapath_taint_track_word.md
Name: multiplier_datapath_taint_track_word

Overview:
- Datapath stage directly downstream of the sequential multiplier controller.
- Holds the multiplicand, multiplier and shift-add result registers.
- Executes the controller's strobes (mdld, mrld, rsclear, rsload, rsshr) and returns the multiplier register word to the controller.
- Propagates one word-level taint bit per register and captures the finished product into an output holding register with a one-cycle valid pulse.

Parameters:
- WIDTH, 4, operand width in bits; must be >= 2. Product width is 2*WIDTH.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low (asserted at 0)
- multiplicand_in  in  WIDTH  operand A
- multiplicand_in_t  in  1  taint of operand A
- multiplier_in  in  WIDTH  operand B
- multiplier_in_t  in  1  taint of operand B
- mdld, mdld_t  in  1,1  load multiplicand register; strobe taint
- mrld, mrld_t  in  1,1  load multiplier register; strobe taint
- rsclear, rsclear_t  in  1,1  clear result register; strobe taint
- rsload, rsload_t  in  1,1  add multiplicand into result upper part; strobe taint
- rsshr, rsshr_t  in  1,1  logical shift result right by 1; strobe taint
- productDone, productDone_t  in  1,1  controller completion strobe; strobe taint
- multiplierReg  out  WIDTH  multiplier register contents, to controller
- multiplierReg_t  out  1  multiplier register taint
- product  out  2*WIDTH  captured product, held until the next capture
- product_t  out  1  taint of the captured product
- product_valid  out  1  one-cycle pulse when product updates
- product_valid_t  out  1  taint of product_valid

Behaviour:
- Reset (rst=0, async): all registers, outputs and taints go to 0, including the pending flag. Reset mid-multiply discards everything; no product_valid is issued afterwards for the aborted operation.
- Multiplicand register md, WIDTH bits: mdld=1 loads md <= multiplicand_in.
- Multiplier register mr, WIDTH bits: mrld=1 loads mr <= multiplier_in. multiplierReg = mr, combinational from the register.
- Result register rs, 2*WIDTH+1 bits; bit 2*WIDTH is the carry. Operation priority: rsclear > rsload > rsshr.
  - rsclear: rs <= 0.
  - rsload: rs[2W:W] <= rs[2W-1:W] + md, zero-extended to W+1 bits; rs[W-1:0] unchanged.
  - rsshr: rs <= {1'b0, rs[2W:1]}.
  - No strobe: rs holds.
- Taint rule for a register loaded when enable en is 1 (md from mdld with multiplicand_in_t; mr from mrld with multiplier_in_t):
  - en=1, en_t=0: reg_t <= data_t.
  - en_t=1: reg_t <= reg_t | data_t | 1, because either outcome was possible.
  - en=0, en_t=0: reg_t holds.
- rs_t:
  - rsclear=1 and rsclear_t=0: rs_t <= 0.
  - Otherwise: rs_t <= rs_t | rsclear_t | rsload_t | rsshr_t | ((rsload|rsload_t) & md_t).
- Completion:
  - productDone=1 sets the pending flag at that edge. The strobe coincides with the final rsshr, so rs is final after this edge.
  - On the next edge with pending=1: product <= rs[2W-1:0]; product_t <= rs_t | pend_t; product_valid <= 1; pending <= 0.
  - product_valid is 0 on every other cycle.
  - Latency: product_valid is high in the second cycle after the productDone cycle.
  - pend_t <= productDone_t at every edge. product_valid_t <= pend_t at every edge.
  - A tainted productDone with productDone=0 sets no pending, but still raises product_valid_t one cycle later.
- Simultaneous events:
  - productDone while pending=1: pending stays 1; the capture uses rs at the following edge.
  - mdld together with rsload: the add uses the old md; the new md is visible from the next cycle.
- Overflow: none possible. The carry bit absorbs the add, and the final product always fits in 2*WIDTH bits.

Decomposition:
- Shared package (mult_taint_pkg): the strobe bundle struct (mdld, mrld, rsclear, rsload, rsshr, productDone, each with _t), shared with the controller.
- Package also holds the function taint_load(en, en_t, old_t, data_t) so the controller and datapath share one rule.
- One sub-module, taint_load_reg (parameter W): a data register with load enable and the taint rule above, instantiated for md and mr.
- rs and the completion capture stay inline.

Test Plan:
- WIDTH=4, A=3, B=5, all taints 0, controller strobe sequence -> product=15 (0x0F), product_t=0, product_valid pulses exactly once, 2 cycles after productDone.
- A=15, B=15 -> product=225 (0xE1); rs[8] carry is exercised mid-sequence; product_t=0.
- A=0, B=9 and A=9, B=0 -> product=0; multiplierReg=9 in the first case and 0 in the second, after mrld.
- A=6, B=2, multiplicand_in_t=1 only -> product=12, product_t=1, multiplierReg_t=0.
- rsclear=1, rsclear_t=1 with all other taints 0 -> rs=0, rs_t=1. The next rsclear with rsclear_t=0 returns rs_t to 0.
- Drive rst=0 asynchronously (between clock edges) after 3 shift steps of A=7, B=7 -> all outputs 0 immediately. No product_valid until a fresh sequence completes; that sequence gives product=49.
